// File: rtl/pe_mac_array_if.sv
// pe_mac_array_if: control, operand stream and result stream
// bundle for the MAC array (master = producer/consumer side).
interface pe_mac_array_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 8,
  parameter int MAX_K  = 16,
  parameter int KW     = $clog2(MAX_K + 1)
);
  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   first;
  logic                   last;
  logic                   signed_mode;
  logic                   relu_en;
  logic [4:0]             shift;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      ifmap;
  logic [ROWS*DATA_W-1:0] weight;
  logic [ROWS*ACC_W-1:0]  bias;
  logic                   out_valid;
  logic                   out_ready;
  logic [ROWS*ACC_W-1:0]  ofmap;
  logic                   done;
  logic                   busy;

  modport master (
    output start, k_len, first, last,
    output signed_mode, relu_en, shift,
    output in_valid, ifmap, weight, bias,
    output out_ready,
    input  in_ready, out_valid, ofmap,
    input  done, busy
  );

  modport slave (
    input  start, k_len, first, last,
    input  signed_mode, relu_en, shift,
    input  in_valid, ifmap, weight, bias,
    input  out_ready,
    output in_ready, out_valid, ofmap,
    output done, busy
  );
endinterface

// File: rtl/pe_mac_array.sv
// pe_mac_array: ROWS-lane MAC array with bias load, multi-pass
// accumulation and shift/ReLU post-processing of the ofmap.
module pe_mac_array #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 8,
  parameter int MAX_K  = 16,
  parameter int KW     = $clog2(MAX_K + 1)
) (
  input logic           clk,
  input logic           rst,
  pe_mac_array_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    POST,
    OUT
  } state_e;

  state_e                state_q;
  logic [KW-1:0]         klen_q;
  logic [KW-1:0]         cnt_q;
  logic [KW-1:0]         cnt_d;
  logic                  last_q;
  logic                  sgn_q;
  logic                  relu_q;
  logic [4:0]            shift_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  done_q;
  logic [ROWS*ACC_W-1:0] ofmap_q;
  logic [ACC_W-1:0]      acc_q  [ROWS];
  logic [ACC_W-1:0]      mac_d  [ROWS];
  logic [ACC_W-1:0]      post_d [ROWS];
  logic [ACC_W-1:0]      w_ext  [ROWS];
  logic [ACC_W-1:0]      a_ext;
  logic                  beat;

  assign beat  = io.in_valid && in_ready_q;
  assign cnt_d = cnt_q + KW'(1);

  // Operands widened to ACC_W first so the product wraps mod 2^ACC_W.
  always_comb begin
    if (sgn_q) begin
      a_ext = {{(ACC_W-DATA_W){io.ifmap[DATA_W-1]}}, io.ifmap};
    end else begin
      a_ext = {{(ACC_W-DATA_W){1'b0}}, io.ifmap};
    end
    for (int r = 0; r < ROWS; r++) begin
      if (sgn_q) begin
        w_ext[r] = {{(ACC_W-DATA_W){io.weight[r*DATA_W+DATA_W-1]}},
                    io.weight[r*DATA_W +: DATA_W]};
        post_d[r] = $signed(acc_q[r]) >>> shift_q;
      end else begin
        w_ext[r] = {{(ACC_W-DATA_W){1'b0}},
                    io.weight[r*DATA_W +: DATA_W]};
        post_d[r] = acc_q[r] >> shift_q;
      end
      if (relu_q && sgn_q && post_d[r][ACC_W-1]) begin
        post_d[r] = '0;
      end
      mac_d[r] = acc_q[r] + a_ext * w_ext[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      klen_q      <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      sgn_q       <= 1'b0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ofmap_q     <= '0;
      for (int r = 0; r < ROWS; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (io.start) begin
            klen_q  <= io.k_len;
            last_q  <= io.last;
            sgn_q   <= io.signed_mode;
            relu_q  <= io.relu_en;
            shift_q <= io.shift;
            cnt_q   <= '0;
            if (io.first) begin
              for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= io.bias[r*ACC_W +: ACC_W];
              end
            end
            if (io.k_len != '0) begin
              state_q    <= MAC;
              in_ready_q <= 1'b1;
            end else if (io.last) begin
              state_q <= POST;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        MAC: begin
          if (beat) begin
            for (int r = 0; r < ROWS; r++) begin
              acc_q[r] <= mac_d[r];
            end
            cnt_q <= cnt_d;
            if (cnt_d == klen_q) begin
              in_ready_q <= 1'b0;
              if (last_q) begin
                state_q <= POST;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        POST: begin
          for (int r = 0; r < ROWS; r++) begin
            ofmap_q[r*ACC_W +: ACC_W] <= post_d[r];
          end
          out_valid_q <= 1'b1;
          done_q      <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          // Result consumed: next pass must start from a clean slate.
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            for (int r = 0; r < ROWS; r++) begin
              acc_q[r] <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.done      = done_q;
  assign io.busy      = (state_q != IDLE);
  assign io.ofmap     = ofmap_q;

endmodule

// File: tb/tb_pe_mac_array.sv
// tb_pe_mac_array: directed and randomized passes through the
// MAC array, checked against a per-lane arithmetic reference.
module tb_pe_mac_array;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int ROWS   = 8;
  localparam int MAX_K  = 16;
  localparam int KW     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pe_mac_array_if #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .MAX_K(MAX_K), .KW(KW)
  ) io ();

  pe_mac_array #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .MAX_K(MAX_K), .KW(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_total = 0;
  int done_last = -1;
  int ov_total = 0;
  int ov_last = -1;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (io.done === 1'b1) begin
      done_total = done_total + 1;
      done_last = cyc;
    end
    if (io.out_valid === 1'b1 && !ov_prev) begin
      ov_total = ov_total + 1;
      ov_last = cyc;
    end
    ov_prev = (io.out_valid === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // reference model: plain integer arithmetic per lane
  bit [31:0] m_acc [ROWS];
  logic [7:0] if_v [16];
  logic [63:0] w_v [16];
  logic [255:0] bias_v;

  // per-pass observations
  int start_cyc, beat_cyc, d_n, d_cyc, o_n, o_cyc, stalls;
  bit tmo, stable_ok, busy_ok, ready_after, out_after, busy_after;
  bit busy_start;
  logic [255:0] res, exp_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_load();
    for (int r = 0; r < ROWS; r++) m_acc[r] = bias_v[r*32 +: 32];
  endtask

  task automatic m_clear();
    for (int r = 0; r < ROWS; r++) m_acc[r] = 0;
  endtask

  task automatic m_beat(input bit s, input logic [7:0] a,
                        input logic [63:0] w);
    int x, y;
    for (int r = 0; r < ROWS; r++) begin
      logic [7:0] wr;
      wr = w[r*8 +: 8];
      if (s) begin
        x = int'(signed'(a));
        y = int'(signed'(wr));
      end else begin
        x = int'(a);
        y = int'(wr);
      end
      m_acc[r] = m_acc[r] + 32'(x * y);
    end
  endtask

  function automatic logic [255:0] m_post(input bit s, input bit rl,
                                          input logic [4:0] sh);
    logic [255:0] o;
    int v;
    for (int r = 0; r < ROWS; r++) begin
      if (s) v = int'(m_acc[r]) >>> sh;
      else v = int'(m_acc[r] >> sh);
      if (rl && s && v < 0) v = 0;
      o[r*32 +: 32] = v;
    end
    return o;
  endfunction

  task automatic drive_pass(input bit f, input bit l, input bit s,
                            input bit rl, input logic [4:0] sh,
                            input int k, input int gm, input int hold);
    int n, guard, pi, d_base, o_base;
    bit v, acc_ok;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    d_base = done_total;
    o_base = ov_total;
    stalls = 0; tmo = 0; stable_ok = 1; busy_ok = 1;
    io.start = 1; io.k_len = KW'(k); io.first = f; io.last = l;
    io.signed_mode = s; io.relu_en = rl; io.shift = sh;
    io.bias = bias_v;
    tick();
    start_cyc = cyc;
    beat_cyc = cyc;
    busy_start = io.busy;
    io.start = 0;
    io.bias = {8{$urandom}};
    if (f) m_load();
    n = 0; guard = 0; pi = 0;
    while (n < k && guard < 200) begin
      if (gm == 0) v = 1;
      else if (gm == 1) v = ($urandom_range(0, 2) != 0);
      else begin
        v = pat[pi % 7];
        pi++;
      end
      io.in_valid = v;
      io.ifmap = v ? if_v[n] : 8'($urandom);
      io.weight = v ? w_v[n] : {$urandom, $urandom};
      if (v && io.in_ready !== 1'b1) stalls++;
      acc_ok = v && (io.in_ready === 1'b1);
      tick();
      if (acc_ok) begin
        m_beat(s, if_v[n], w_v[n]);
        n++;
        beat_cyc = cyc;
      end
      guard++;
    end
    if (n < k) tmo = 1;
    io.in_valid = 0;
    ready_after = io.in_ready;
    if (l) begin
      guard = 0;
      while (io.out_valid !== 1'b1 && guard < 10) begin
        tick();
        guard++;
      end
      if (io.out_valid !== 1'b1) tmo = 1;
      res = io.ofmap;
      exp_res = m_post(s, rl, sh);
      for (int i = 0; i < hold; i++) begin
        io.out_ready = 0;
        io.start = 1;
        io.first = 1;
        io.k_len = KW'($urandom_range(1, 16));
        tick();
        if (io.ofmap !== res || io.out_valid !== 1'b1) stable_ok = 0;
        if (io.busy !== 1'b1) busy_ok = 0;
      end
      io.start = 0;
      io.out_ready = 1;
      tick();
      io.out_ready = 0;
      m_clear();
    end else begin
      tick();
    end
    out_after = io.out_valid;
    busy_after = io.busy;
    d_n = done_total - d_base;
    d_cyc = done_last;
    o_n = ov_total - o_base;
    o_cyc = ov_last;
  endtask

  task automatic set_basic_data();
    for (int i = 0; i < 4; i++) begin
      if_v[i] = 8'(i + 1);
      for (int r = 0; r < ROWS; r++) w_v[i][r*8 +: 8] = 8'(r + 1);
    end
    for (int r = 0; r < ROWS; r++) bias_v[r*32 +: 32] = 32'(100 * r);
  endtask

  task automatic test_reset();
    rst = 1;
    io.start = 1; io.k_len = 5'd3; io.first = 1; io.last = 1;
    io.in_valid = 1; io.out_ready = 1;
    tick();
    tick();
    vectors++;
    if (io.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b want 0", io.busy);
    end
    vectors++;
    if (io.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b want 0", io.in_ready);
    end
    vectors++;
    if (io.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %b want 0", io.out_valid);
    end
    vectors++;
    if (io.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done got %b want 0", io.done);
    end
    vectors++;
    if (io.ofmap !== '0) begin
      miscompares++;
      $display("FAIL reset_ofmap got %h want 0", io.ofmap);
    end
    io.start = 0; io.in_valid = 0; io.out_ready = 0;
    rst = 0;
    m_clear();
    tick();
  endtask

  task automatic test_basic();
    logic [255:0] want;
    set_basic_data();
    for (int r = 0; r < ROWS; r++) want[r*32 +: 32] = 32'(100*r + 10*(r+1));
    drive_pass(1, 1, 0, 0, 0, 4, 0, 0);
    vectors++;
    if (res !== want) begin
      miscompares++;
      $display("FAIL basic_ofmap got %h want %h", res, want);
    end
    vectors++;
    if (tmo || o_cyc != beat_cyc + 1) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want %0d", o_cyc - beat_cyc,
               1);
    end
    vectors++;
    if (d_n != 1 || d_cyc != o_cyc) begin
      miscompares++;
      $display("FAIL basic_done got n=%0d at %0d want 1 at %0d",
               d_n, d_cyc, o_cyc);
    end
    vectors++;
    if (busy_start !== 1'b1 || ready_after !== 1'b0 || stalls != 0) begin
      miscompares++;
      $display("FAIL basic_handshake got busy=%b rdy=%b stalls=%0d want 1 0 0",
               busy_start, ready_after, stalls);
    end
    vectors++;
    if (out_after !== 1'b0 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_release got ov=%b busy=%b want 0 0",
               out_after, busy_after);
    end
  endtask

  task automatic test_signed_relu();
    if_v[0] = 8'hFF;
    w_v[0] = {8{8'h02}};
    bias_v = '0;
    drive_pass(1, 1, 1, 0, 0, 1, 0, 0);
    vectors++;
    if (res !== {8{32'hFFFF_FFFE}}) begin
      miscompares++;
      $display("FAIL signed_ofmap got %h want %h", res, {8{32'hFFFF_FFFE}});
    end
    drive_pass(1, 1, 1, 1, 0, 1, 0, 0);
    vectors++;
    if (res !== '0) begin
      miscompares++;
      $display("FAIL relu_ofmap got %h want 0", res);
    end
  endtask

  task automatic test_multipass();
    logic [255:0] want;
    set_basic_data();
    for (int r = 0; r < ROWS; r++) want[r*32 +: 32] = 32'(100*r + 20*(r+1));
    drive_pass(1, 0, 0, 0, 0, 4, 0, 0);
    vectors++;
    if (tmo || d_n != 1 || d_cyc != beat_cyc) begin
      miscompares++;
      $display("FAIL passA_done got n=%0d at %0d want 1 at %0d",
               d_n, d_cyc, beat_cyc);
    end
    vectors++;
    if (o_n != 0 || busy_after !== 1'b0 || ready_after !== 1'b0) begin
      miscompares++;
      $display("FAIL passA_idle got ov=%0d busy=%b rdy=%b want 0 0 0",
               o_n, busy_after, ready_after);
    end
    drive_pass(0, 1, 0, 0, 0, 4, 0, 0);
    vectors++;
    if (res !== want) begin
      miscompares++;
      $display("FAIL passB_ofmap got %h want %h", res, want);
    end
    vectors++;
    if (d_n != 1 || o_n != 1 || d_cyc != o_cyc) begin
      miscompares++;
      $display("FAIL passB_done got n=%0d ov=%0d want 1 1", d_n, o_n);
    end
  endtask

  task automatic test_back_to_back_gaps();
    logic [255:0] want;
    set_basic_data();
    for (int r = 0; r < ROWS; r++) want[r*32 +: 32] = 32'(100*r + 10*(r+1));
    drive_pass(1, 1, 0, 0, 0, 4, 2, 5);
    vectors++;
    if (res !== want) begin
      miscompares++;
      $display("FAIL gaps_ofmap got %h want %h", res, want);
    end
    vectors++;
    if (!stable_ok || !busy_ok) begin
      miscompares++;
      $display("FAIL hold_stable got stable=%b busy=%b want 1 1",
               stable_ok, busy_ok);
    end
    vectors++;
    if (tmo || stalls != 0 || o_cyc != beat_cyc + 1) begin
      miscompares++;
      $display("FAIL gaps_timing got lat=%0d stalls=%0d want 1 0",
               o_cyc - beat_cyc, stalls);
    end
    vectors++;
    if (out_after !== 1'b0 || d_n != 1) begin
      miscompares++;
      $display("FAIL gaps_release got ov=%b done=%0d want 0 1",
               out_after, d_n);
    end
  endtask

  task automatic test_kzero();
    for (int r = 0; r < ROWS; r++) bias_v[r*32 +: 32] = 32'h100;
    drive_pass(1, 1, 0, 0, 5'd4, 0, 0, 0);
    vectors++;
    if (res !== {8{32'h10}}) begin
      miscompares++;
      $display("FAIL kzero_ofmap got %h want %h", res, {8{32'h10}});
    end
    vectors++;
    if (tmo || o_cyc != start_cyc + 1 || d_n != 1) begin
      miscompares++;
      $display("FAIL kzero_timing got lat=%0d done=%0d want 1 1",
               o_cyc - start_cyc, d_n);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = done_total;
    bias_v = {8{$urandom}};
    io.start = 1; io.k_len = 5'd4; io.first = 1; io.last = 1;
    io.signed_mode = 0; io.relu_en = 0; io.shift = 0;
    io.bias = bias_v;
    tick();
    io.start = 0;
    io.in_valid = 1; io.ifmap = 8'd7; io.weight = {8{8'd3}};
    tick();
    rst = 1;
    io.ifmap = 8'd9;
    tick();
    vectors++;
    if (io.busy !== 1'b0 || io.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_ctrl got busy=%b rdy=%b want 0 0",
               io.busy, io.in_ready);
    end
    vectors++;
    if (io.out_valid !== 1'b0 || io.done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_out got ov=%b done=%b want 0 0",
               io.out_valid, io.done);
    end
    vectors++;
    if (io.ofmap !== '0) begin
      miscompares++;
      $display("FAIL rstmid_ofmap got %h want 0", io.ofmap);
    end
    rst = 0;
    io.in_valid = 0;
    repeat (4) tick();
    vectors++;
    if (done_total != base) begin
      miscompares++;
      $display("FAIL rstmid_nodone got %0d want 0", done_total - base);
    end
    m_clear();
    if_v[0] = 8'($urandom); w_v[0] = {$urandom, $urandom};
    if_v[1] = 8'($urandom); w_v[1] = {$urandom, $urandom};
    drive_pass(0, 1, 0, 0, 0, 2, 0, 0);
    vectors++;
    if (res !== exp_res) begin
      miscompares++;
      $display("FAIL rstmid_acc_clear got %h want %h", res, exp_res);
    end
  endtask

  task automatic test_random();
    bit f, l, s, rl;
    logic [4:0] sh;
    int k;
    for (int p = 0; p < 30; p++) begin
      f = $urandom_range(0, 1);
      l = $urandom_range(0, 2) != 0;
      s = $urandom_range(0, 1);
      rl = $urandom_range(0, 1);
      sh = 5'($urandom_range(0, 31));
      k = $urandom_range(0, 16);
      bias_v = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 16; i++) begin
        if_v[i] = 8'($urandom);
        w_v[i] = {$urandom, $urandom};
      end
      drive_pass(f, l, s, rl, sh, k, 1, $urandom_range(0, 3));
      vectors++;
      if (tmo || stalls != 0 || d_n != 1) begin
        miscompares++;
        $display("FAIL rand%0d_flow got tmo=%b stalls=%0d done=%0d", p,
                 tmo, stalls, d_n);
      end
      if (l) begin
        vectors++;
        if (res !== exp_res) begin
          miscompares++;
          $display("FAIL rand%0d_ofmap got %h want %h", p, res, exp_res);
        end
        vectors++;
        if (o_cyc != beat_cyc + 1 || d_cyc != o_cyc || !stable_ok) begin
          miscompares++;
          $display("FAIL rand%0d_timing got lat=%0d stable=%b want 1 1", p,
                   o_cyc - beat_cyc, stable_ok);
        end
      end else begin
        vectors++;
        if (d_cyc != beat_cyc || o_n != 0 || busy_after !== 1'b0) begin
          miscompares++;
          $display("FAIL rand%0d_partial got done@%0d ov=%0d want @%0d 0",
                   p, d_cyc, o_n, beat_cyc);
        end
      end
    end
  endtask

  initial begin
    io.start = 0; io.k_len = '0; io.first = 0; io.last = 0;
    io.signed_mode = 0; io.relu_en = 0; io.shift = '0;
    io.in_valid = 0; io.ifmap = '0; io.weight = '0; io.bias = '0;
    io.out_ready = 0;
    test_reset();
    test_basic();
    test_signed_relu();
    test_multipass();
    test_back_to_back_gaps();
    test_kzero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pe_mac_array.md
PE_MAC_ARRAY -- requirements
Module: pe_mac_array

Interface
REQ-001 Parameter DATA_W, 8, operand width of ifmap and each weight.
REQ-002 Parameter ACC_W, 32, accumulator, bias and ofmap lane width.
REQ-003 Parameter ROWS, 8, number of parallel MAC lanes (output channels).
REQ-004 Parameter MAX_K, 16, maximum input elements per pass; KW = clog2(MAX_K+1).
REQ-005 The clock is clk (input, 1): all state updates on its rising edge.
REQ-006 The reset is rst (input, 1): synchronous, active-high.
REQ-007 start  input  1  pass request, sampled only in IDLE.
REQ-008 k_len  input  KW  number of input beats in the pass; captured on start.
REQ-009 first  input  1  pass loads bias into accumulators; captured on start.
REQ-010 last  input  1  pass ends with post-processing and output; captured on start.
REQ-011 signed_mode  input  1  operands and bias are two's complement; 0 means unsigned; captured on start.
REQ-012 relu_en  input  1  clamp negative results to 0; captured on start.
REQ-013 shift  input  5  right-shift amount applied at post-processing; captured on start.
REQ-014 in_valid  input  1  ifmap/weight beat valid.
REQ-015 in_ready  output  1  array accepts a beat.
REQ-016 ifmap  input  DATA_W  input element broadcast to all lanes.
REQ-017 weight  input  ROWS*DATA_W  per-lane weight; lane r at bits [r*DATA_W +: DATA_W].
REQ-018 bias  input  ROWS*ACC_W  per-lane bias; lane r at bits [r*ACC_W +: ACC_W]; sampled on start when first=1.
REQ-019 out_valid  output  1  ofmap holds a result.
REQ-020 out_ready  input  1  consumer accepts ofmap.
REQ-021 ofmap  output  ROWS*ACC_W  per-lane results, same lane packing as bias.
REQ-022 done  output  1  one-cycle pulse at the end of every pass.
REQ-023 busy  output  1  high whenever the state is not IDLE.

Function
REQ-024 The FSM SHALL have the states IDLE, MAC, POST and OUT.
REQ-025 IDLE SHALL transition on start to MAC, capturing all mode inputs; when first=1, acc[r] SHALL be loaded with bias lane r, else acc SHALL be kept.
REQ-026 start with k_len=0 SHALL skip MAC: go to POST if last=1, else return to IDLE with a done pulse.
REQ-027 MAC SHALL drive in_ready=1; each cycle with in_valid&&in_ready: acc[r] <= acc[r] + ext(ifmap)*ext(weight_r) and beat count +1.
REQ-028 ext() SHALL be a sign-extension when signed_mode=1, else a zero-extension, to ACC_W; sums wrap modulo 2^ACC_W with no saturation.
REQ-029 Cycles with in_valid=0 in MAC SHALL leave acc and the count unchanged; gaps of any length are legal.
REQ-030 After the k_len-th accepted beat, the block SHALL go to POST if last=1, else to IDLE; done SHALL pulse the cycle after that beat, and in_ready SHALL drop that same cycle.
REQ-031 POST (one cycle) SHALL register res[r] = acc[r] >>> shift (arithmetic if signed_mode, logical otherwise), then, if relu_en && signed_mode && res negative, res=0, into ofmap, then go to OUT.
REQ-032 OUT SHALL hold out_valid=1 with ofmap stable until out_ready=1; in that cycle, go to IDLE, clear acc to 0 and deassert out_valid next cycle.
REQ-033 done SHALL pulse on entry to OUT for last passes (i.e. concurrently with out_valid rising).
REQ-034 start outside IDLE SHALL be ignored; ofmap SHALL hold its last value after out_valid falls.
REQ-035 Latency: the last beat at cycle t -> out_valid at t+2 (MAC->POST->OUT).
REQ-036 Multi-pass accumulation (first=1 ... first=0, last=1) SHALL yield bias + sum of all beats of all passes.

Reset
REQ-037 While rst=1: state IDLE, all acc=0, ofmap=0, out_valid=0, in_ready=0, done=0, busy=0; captured mode registers cleared.
REQ-038 rst SHALL override all other inputs, including mid-MAC or mid-OUT, aborting the pass without a done pulse.

Verification
REQ-039 ROWS=8, unsigned, first=last=1, k_len=4, ifmap 1,2,3,4, weight lane r = r+1, bias lane r = 100*r -> ofmap lane r = 100*r + 10*(r+1), out_valid 2 cycles after the 4th beat.
REQ-040 signed_mode=1, k_len=1, ifmap 0xFF, weight 0x02, bias 0 -> lane = 0xFFFFFFFE; repeat with relu_en=1 -> 0x00000000.
REQ-041 Pass A (first=1, last=0, k_len=4, as REQ-039) then pass B (first=0, last=1, same data) -> lane r = 100*r + 20*(r+1); done pulses after both passes; out_valid only after B.
REQ-042 in_valid toggled 1,0,0,1,1,0,1 during MAC and out_ready held low 5 cycles with start pulsed -> same result as REQ-039, ofmap stable, start ignored, busy=1.
REQ-043 bias 0x00000100, k_len=0, last=1, shift=4 -> ofmap 0x00000010; rst asserted on 2nd MAC beat -> all outputs 0 next cycle, no done.
